dlms_adapt_ctrl: RTL

Adaptation controller for the pipelined DLMS FIR datapath. It sequences the filter through coefficient clear, pipeline fill, fast-step training, slow-step tracking and frozen operation. It decides when the coefficient update may run and which step size applies, based on a leaky average of the filter error magnitude. It sits beside the DLMS filter, consumes its `e_out`, and drives the filter's coefficient-clear, update-enable and step-size select inputs.

---
 rtl/dlms_pkg.sv | 21 ++
 rtl/abs_leaky_avg.sv | 28 ++
 rtl/dlms_adapt_ctrl.sv | 87 ++++++++
 3 files changed

// File: rtl/dlms_pkg.sv
// dlms_pkg: shared state codes, step-size codes and defaults for the DLMS blocks.
package dlms_pkg;
    localparam int W2_DEF = 16;
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FILL  = 3'd2,
        S_TRAIN = 3'd3,
        S_TRACK = 3'd4,
        S_HOLD  = 3'd5
    } state_t;
    localparam logic [1:0] MU_NONE  = 2'd0;
    localparam logic [1:0] MU_TRAIN = 2'd1;
    localparam logic [1:0] MU_TRACK = 2'd2;
    function automatic logic [1:0] mu_of(state_t s);
        return s == S_TRAIN ? MU_TRAIN : s == S_TRACK ? MU_TRACK : MU_NONE;
    endfunction
    function automatic int cw(int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/abs_leaky_avg.sv
// abs_leaky_avg: saturating |e| followed by a first-order leaky average.
module abs_leaky_avg import dlms_pkg::*; #(
    parameter int W2     = W2_DEF,
    parameter int AVG_SH = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 hold,
    input  logic signed [W2-1:0] e,
    output logic        [W2-1:0] avg
);
    logic [W2-1:0] neg, mag;
    logic signed [W2:0] diff, nxt;
    always_comb begin
        neg  = -e;
        // only the most negative input still has its MSB set after negation
        mag  = !e[W2-1] ? e : neg[W2-1] ? {1'b0, {(W2-1){1'b1}}} : neg;
        diff = $signed({1'b0, mag}) - $signed({1'b0, avg});
        nxt  = $signed({1'b0, avg}) + (diff >>> AVG_SH);
    end
    always_ff @(posedge clk) begin
        if (!reset || clr)
            avg <= '0;
        else if (!hold)
            avg <= W2'(nxt);
    end
endmodule

// File: rtl/dlms_adapt_ctrl.sv
// dlms_adapt_ctrl: sequences DLMS clear/fill/train/track/hold and selects step size.
module dlms_adapt_ctrl import dlms_pkg::*; #(
    parameter int W2        = W2_DEF,
    parameter int DELAY     = 3,
    parameter int TRAIN_LEN = 256,
    parameter int CONV_THR  = 64,
    parameter int DIV_THR   = 256,
    parameter int CONV_CNT  = 16,
    parameter int AVG_SH    = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 freeze,
    input  logic signed [W2-1:0] e_in,
    output logic                 clr_coef,
    output logic                 adapt_en,
    output logic [1:0]           mu_sel,
    output logic                 converged,
    output logic                 timeout,
    output logic [W2-1:0]        err_avg,
    output logic [2:0]           state
);
    localparam int FW = cw(DELAY + 1);
    localparam int TW = cw(TRAIN_LEN);
    localparam int CW = cw(CONV_CNT);
    state_t st, nxt;
    logic [FW-1:0] fill_cnt;
    logic [TW-1:0] train_cnt;
    logic [CW-1:0] conv_cnt;
    logic below, conv_hit, train_hit, stay_train;
    assign state = st;
    abs_leaky_avg #(.W2(W2), .AVG_SH(AVG_SH)) u_avg (
        .clk   (clk),
        .reset (reset),
        .clr   (nxt == S_CLEAR),
        .hold  (st == S_IDLE || st == S_CLEAR),
        .e     (e_in),
        .avg   (err_avg)
    );
    always_comb begin
        below      = err_avg < W2'(CONV_THR);
        conv_hit   = st == S_TRAIN && below && conv_cnt == CW'(CONV_CNT - 1);
        train_hit  = st == S_TRAIN && train_cnt == TW'(TRAIN_LEN - 1);
        nxt        = st;
        if (stop)
            nxt = S_IDLE;
        else if (start)
            nxt = S_CLEAR;
        else
            case (st)
                S_IDLE:  nxt = S_IDLE;
                S_CLEAR: nxt = S_FILL;
                S_FILL:  nxt = fill_cnt == FW'(DELAY) ? S_TRAIN : S_FILL;
                S_TRAIN: nxt = conv_hit || train_hit ? S_TRACK : S_TRAIN;
                S_TRACK: nxt = freeze ? S_HOLD : err_avg > W2'(DIV_THR) ? S_TRAIN : S_TRACK;
                S_HOLD:  nxt = freeze ? S_HOLD : S_TRACK;
                default: nxt = S_IDLE;
            endcase
        stay_train = st == S_TRAIN && nxt == S_TRAIN;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            st        <= S_IDLE;
            clr_coef  <= 1'b0;
            adapt_en  <= 1'b0;
            mu_sel    <= MU_NONE;
            converged <= 1'b0;
            timeout   <= 1'b0;
            fill_cnt  <= '0;
            train_cnt <= '0;
            conv_cnt  <= '0;
        end else begin
            st        <= nxt;
            clr_coef  <= nxt == S_CLEAR;
            adapt_en  <= nxt == S_TRAIN || nxt == S_TRACK;
            mu_sel    <= mu_of(nxt);
            fill_cnt  <= st == S_FILL && nxt == S_FILL ? (fill_cnt == '1 ? fill_cnt : fill_cnt + 1'b1) : '0;
            train_cnt <= stay_train ? (train_cnt == '1 ? train_cnt : train_cnt + 1'b1) : '0;
            conv_cnt  <= stay_train && below ? (conv_cnt == '1 ? conv_cnt : conv_cnt + 1'b1) : '0;
            // leaving TRAIN on a simultaneous hit counts as convergence, not timeout
            converged <= st == S_TRAIN && nxt == S_TRACK ? conv_hit : (nxt == S_TRACK || nxt == S_HOLD) && converged;
            timeout   <= nxt == S_CLEAR || nxt == S_IDLE ? 1'b0 : timeout || (st == S_TRAIN && nxt == S_TRACK && !conv_hit);
        end
    end
endmodule
